// File: rtl/nios2_qsys_oci_dct_packer.sv
// DCT trace packer: packs SYM_W-bit symbols LSB-first into a DEPTH-symbol word
// and hands full or flushed words to a one-entry output register. Optional idle auto-flush: DCT_TIMEOUT_FLUSH_EN.
module nios2_qsys_oci_dct_packer #(
    parameter int SYM_W        = 2,
    parameter int DEPTH        = 15,
    parameter int CNT_W        = 4,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sym_valid,
    input  logic [SYM_W-1:0]       sym_data,
    output logic                   sym_ready,
    input  logic                   flush,
    output logic [SYM_W*DEPTH-1:0] dct_buffer,
    output logic [CNT_W-1:0]       dct_count,
    output logic                   word_valid,
    output logic [SYM_W*DEPTH-1:0] word_data,
    output logic [CNT_W-1:0]       word_count,
    input  logic                   word_ready
);

    localparam int               BUF_W = SYM_W * DEPTH;
    localparam logic [0:0]       FILL  = 1'b0;
    localparam logic [0:0]       STALL = 1'b1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    // Reject configurations where the counter cannot represent a full word.
    if (CNT_W < $clog2(DEPTH + 1) || IDLE_TIMEOUT < 2) begin : g_param_check
        $error("nios2_qsys_oci_dct_packer: CNT_W too small for DEPTH or IDLE_TIMEOUT < 2");
    end

    logic [0:0]       state;
    logic             flush_pend;
    logic             accept;
    logic             slot_free;
    logic             flush_req;
    logic             full_next;
    logic             emit;
    logic             do_emit;
    logic             timeout_flush;
    logic [CNT_W-1:0] cnt_next;
    logic [BUF_W-1:0] buf_next;

    assign sym_ready = (state == FILL) && !flush_pend;
    assign accept    = sym_valid && sym_ready;
    assign cnt_next  = dct_count + {{(CNT_W-1){1'b0}}, accept};
    assign slot_free = !word_valid || word_ready;
    assign flush_req = flush || flush_pend || timeout_flush;
    assign full_next = (cnt_next == FULL);
    assign emit      = full_next || (flush_req && (cnt_next != '0));
    assign do_emit   = emit && slot_free;

    // NOTE: buf_next gets its default before the conditional writes so no latch is inferred.
    always_comb begin
        buf_next = dct_buffer;
        for (int k = 0; k < DEPTH; k++) begin
            if (accept && (dct_count == CNT_W'(k)))
                buf_next[k*SYM_W +: SYM_W] = sym_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            flush_pend <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_count <= '0;
        end else begin
            if (word_valid && word_ready)
                word_valid <= 1'b0;

            if (do_emit) begin
                word_valid <= 1'b1;
                word_data  <= buf_next;
                word_count <= cnt_next;
                dct_buffer <= '0;
                dct_count  <= '0;
                flush_pend <= 1'b0;
                state      <= FILL;
            end else begin
                dct_buffer <= buf_next;
                dct_count  <= cnt_next;
                if (full_next)
                    state <= STALL;
                // An empty flush is simply dropped; a blocked one waits for the slot.
                if (flush_req)
                    flush_pend <= (cnt_next != '0);
            end
        end
    end

`ifdef DCT_TIMEOUT_FLUSH_EN
    localparam int IDLE_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_flush = (idle_cnt == IDLE_LAST);

    // Holds at the threshold so the request stays up until the word can leave.
    always_ff @(posedge clk) begin
        if (reset || accept || do_emit)
            idle_cnt <= '0;
        else if ((dct_count != '0) && (idle_cnt != IDLE_LAST))
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout_flush = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_qsys_oci_dct_packer.sv
// Scoreboard bench for nios2_qsys_oci_dct_packer: directed stimulus pushes
// expected words, a negedge monitor pops and compares on every word transfer.
module tb_nios2_qsys_oci_dct_packer;

    typedef struct packed {
        logic [29:0] data;
        logic [3:0]  count;
    } word_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sym_valid;
    logic [1:0]  sym_data;
    logic        sym_ready;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        word_valid;
    logic [29:0] word_data;
    logic [3:0]  word_count;
    logic        word_ready;

    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];

    always #5 clk = ~clk;

    nios2_qsys_oci_dct_packer dut (
        .clk        (clk),
        .reset      (reset),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_count (word_count),
        .word_ready (word_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h/%0d expected none at %0t",
                         word_data, word_count, $time);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                check("word_data", {2'b00, word_data}, {2'b00, e.data});
                check("word_count", {28'd0, word_count}, {28'd0, e.count});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge on which the symbol was accepted.
    task automatic send_sym(input logic [1:0] d);
        int n;
        n = 0;
        sym_valid = 1'b1;
        sym_data  = d;
        @(negedge clk);
        while (!sym_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got sym_ready=0 expected 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
    endtask

    task automatic pulse_flush;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        sym_valid  = 1'b0;
        sym_data   = 2'b00;
        flush      = 1'b0;
        word_ready = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(1);

        // Reset state
        check("rst_word_valid", {31'd0, word_valid}, 0);
        check("rst_dct_count", {28'd0, dct_count}, 0);
        check("rst_dct_buffer", {2'b00, dct_buffer}, 0);
        check("rst_sym_ready", {31'd0, sym_ready}, 1);

        // Full word 0,1,2,3,... : 0xE4 per four symbols, last three give 0x24
        exp_q.push_back('{data: 30'h24E4_E4E4, count: 4'd15});
        for (int i = 0; i < 15; i++) send_sym(2'(i % 4));
        check("full_latency_valid", {31'd0, word_valid}, 1);
        check("full_latency_count", {28'd0, word_count}, 15);
        check("full_dct_count", {28'd0, dct_count}, 0);
        drain();

        // Backpressure: two words while word_ready is low
        word_ready = 1'b0;
        exp_q.push_back('{data: 30'h1555_5555, count: 4'd15});
        exp_q.push_back('{data: 30'h2AAA_AAAA, count: 4'd15});
        for (int i = 0; i < 15; i++) send_sym(2'b01);
        for (int i = 0; i < 15; i++) send_sym(2'b10);
        cycles(3);
        check("stall_sym_ready", {31'd0, sym_ready}, 0);
        check("stall_dct_count", {28'd0, dct_count}, 15);
        check("stall_dct_buffer", {2'b00, dct_buffer}, {2'b00, 30'h2AAA_AAAA});
        check("held_word_data", {2'b00, word_data}, {2'b00, 30'h1555_5555});
        word_ready = 1'b1;
        cycles(1);
        word_ready = 1'b0;
        check("b2b_word_valid", {31'd0, word_valid}, 1);
        check("b2b_word_data", {2'b00, word_data}, {2'b00, 30'h2AAA_AAAA});
        check("unstall_dct_count", {28'd0, dct_count}, 0);
        check("unstall_sym_ready", {31'd0, sym_ready}, 1);
        cycles(2);
        word_ready = 1'b1;
        drain();

        // Five 2'b11 symbols then flush
        exp_q.push_back('{data: 30'h0000_03FF, count: 4'd5});
        for (int i = 0; i < 5; i++) send_sym(2'b11);
        pulse_flush();
        check("flush_dct_count", {28'd0, dct_count}, 0);
        drain();

        // Flush in the same cycle as the third symbol: 3,2,1 -> 0x1B
        exp_q.push_back('{data: 30'h0000_001B, count: 4'd3});
        send_sym(2'b11);
        send_sym(2'b10);
        sym_valid = 1'b1;
        sym_data  = 2'b01;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        flush     = 1'b0;
        drain();

        // Flush with nothing accumulated produces no word
        cycles(2);
        pulse_flush();
        cycles(4);
        check("empty_flush_no_word", {31'd0, word_valid}, 0);
        check("empty_flush_ready", {31'd0, sym_ready}, 1);

        // Reset with a pending word and a partial accumulator
        word_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_sym(2'b01);
        pulse_flush();
        for (int i = 0; i < 7; i++) send_sym(2'b10);
        check("pre_reset_pending", {31'd0, word_valid}, 1);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("mid_rst_word_valid", {31'd0, word_valid}, 0);
        check("mid_rst_word_data", {2'b00, word_data}, 0);
        check("mid_rst_word_count", {28'd0, word_count}, 0);
        check("mid_rst_dct_buffer", {2'b00, dct_buffer}, 0);
        check("mid_rst_dct_count", {28'd0, dct_count}, 0);
        check("mid_rst_sym_ready", {31'd0, sym_ready}, 1);
        word_ready = 1'b1;
        cycles(2);

        // Idle behaviour after a partial word (four 2'b10 symbols -> 0xAA)
        exp_q.push_back('{data: 30'h0000_00AA, count: 4'd4});
        for (int i = 0; i < 4; i++) send_sym(2'b10);
`ifdef DCT_TIMEOUT_FLUSH_EN
        n = 0;
        while (!word_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_latency", n, 64);
`else
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (word_valid) n++;
        end
        check("no_timeout_word", n, 0);
        check("no_timeout_dct_count", {28'd0, dct_count}, 4);
        pulse_flush();
`endif
        drain();

        cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
